// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stage-control unit for the 5-stage MIPS core: operand forwarding,
// load-use/MDU stalls, exception flush sequencing, debug halt/step and a stall counter.
module pipe_hazard_ctrl #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned MDU_LAT = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned FWD_WB  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en,
    input  logic              debug_step,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              rs_used,
    input  logic              rt_used,
    input  logic              id_is_store,
    input  logic              id_mdu_start,
    input  logic              id_mdu_read,
    input  logic [ADDR_W-1:0] exe_waddr,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic              exe_wen,
    input  logic              mem_wen,
    input  logic              wb_wen,
    input  logic              exe_is_load,
    input  logic              mem_is_load,
    input  logic              exc_req,
    output logic [2:0]        fwd_a_sel,
    output logic [2:0]        fwd_b_sel,
    output logic              fwd_m,
    output logic              pc_redirect,
    output logic              if_en,
    output logic              id_en,
    output logic              exe_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              if_rst,
    output logic              id_rst,
    output logic              exe_rst,
    output logic              mem_rst,
    output logic              wb_rst,
    output logic              mdu_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned MW = $clog2(MDU_LAT + 1);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_step_prev;
    logic [MW-1:0]    r_mdu_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic       w_step_edge;
    logic [3:0] w_fa;
    logic [3:0] w_fb;
    logic       w_fwd_m;
    logic       w_load_use;
    logic       w_mdu_busy;
    logic       w_stall;
    logic       w_active;
    logic       w_halted;
    logic       w_id_adv;

    // Result packs {load_use_stall, sel[2:0]}; EXE > MEM > WB priority.
    function automatic logic [3:0] fwd_calc(input logic used, input logic [ADDR_W-1:0] addr);
        logic [3:0] res;
        res = '0;
        if (used && addr != '0) begin
            if (exe_wen && exe_waddr == addr)
                res = exe_is_load ? 4'b1000 : 4'b0001;
            else if (mem_wen && mem_waddr == addr)
                res = mem_is_load ? 4'b0011 : 4'b0010;
            else if (wb_wen && wb_waddr == addr)
                res = (FWD_WB != 0) ? 4'b0100 : 4'b0000;
        end
        return res;
    endfunction

    always_comb begin
        w_step_edge = debug_step & ~r_step_prev;
        w_fa        = fwd_calc(rs_used, rs_addr);
        w_fb        = fwd_calc(rt_used, rt_addr);
        // Store data can wait for the load result in MEM unless rs stalls anyway.
        w_fwd_m     = w_fb[3] & id_is_store & ~w_fa[3];
        w_load_use  = w_fa[3] | (w_fb[3] & ~w_fwd_m);
        w_mdu_busy  = (r_mdu_cnt != '0);
        w_stall     = w_load_use | (w_mdu_busy & (id_mdu_read | id_mdu_start));
    end

    always_comb begin
        w_next      = r_state;
        w_active    = 1'b0;
        w_halted    = 1'b0;
        pc_redirect = 1'b0;
        if_en       = 1'b1;
        id_en       = 1'b1;
        exe_en      = 1'b1;
        mem_en      = 1'b1;
        wb_en       = 1'b1;
        if_rst      = 1'b0;
        id_rst      = 1'b0;
        exe_rst     = 1'b0;
        mem_rst     = 1'b0;
        wb_rst      = 1'b0;
        fwd_a_sel   = w_fa[2:0];
        fwd_b_sel   = w_fwd_m ? 3'd0 : w_fb[2:0];
        fwd_m       = w_fwd_m;

        case (r_state)
            S_RUN: begin
                w_active = 1'b1;
                if (exc_req)
                    w_next = S_FLUSH;
                else if (debug_en && !w_step_edge)
                    w_next = S_HALT;
            end
            S_FLUSH: begin
                pc_redirect = 1'b1;
                id_rst      = 1'b1;
                exe_rst     = 1'b1;
                mem_rst     = 1'b1;
                w_next      = debug_en ? S_HALT : S_RUN;
            end
            S_HALT: begin
                if (w_step_edge) begin
                    w_active = 1'b1;
                    w_next   = exc_req ? S_FLUSH : (debug_en ? S_HALT : S_RUN);
                end else begin
                    w_halted = 1'b1;
                    if_en    = 1'b0;
                    id_en    = 1'b0;
                    exe_en   = 1'b0;
                    mem_en   = 1'b0;
                    wb_en    = 1'b0;
                    w_next   = debug_en ? S_HALT : S_RUN;
                end
            end
            default: w_next = S_RUN;
        endcase

        if (w_active && w_stall) begin
            if_en   = 1'b0;
            id_en   = 1'b0;
            exe_rst = 1'b1;
        end

        if (rst) begin
            pc_redirect = 1'b0;
            if_en       = 1'b1;
            id_en       = 1'b1;
            exe_en      = 1'b1;
            mem_en      = 1'b1;
            wb_en       = 1'b1;
            if_rst      = 1'b1;
            id_rst      = 1'b1;
            exe_rst     = 1'b1;
            mem_rst     = 1'b1;
            wb_rst      = 1'b1;
            fwd_a_sel   = 3'd0;
            fwd_b_sel   = 3'd0;
            fwd_m       = 1'b0;
        end

        w_id_adv = w_active & ~w_stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_step_prev <= 1'b0;
            r_mdu_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_step_prev <= debug_step;
            if (id_mdu_start && w_id_adv)
                r_mdu_cnt <= MW'(MDU_LAT);
            else if (!w_halted && r_mdu_cnt != '0)
                r_mdu_cnt <= r_mdu_cnt - MW'(1);
            if (w_active && w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign mdu_busy  = w_mdu_busy;
    assign stall_cnt = r_stall_cnt;

endmodule
